mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 80 ++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/LSU request ports and single-port SRAM bus
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              lsu_req;
  logic              lsu_we;
  logic [XLEN/8-1:0] lsu_be;
  logic [ADDR_W-1:0] lsu_addr;
  logic [XLEN-1:0]   lsu_wdata;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [XLEN-1:0]   lsu_rdata;

  logic              sram_cs;
  logic              sram_we;
  logic [XLEN/8-1:0] sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [XLEN-1:0]   sram_wdata;
  logic [XLEN-1:0]   sram_rdata;

  modport slave (
    input  if_req, if_addr, lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata, sram_rdata,
    output if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
    output sram_cs, sram_we, sram_be, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata, sram_rdata,
    input  if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
    input  sram_cs, sram_we, sram_be, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter onto one single-port SRAM, LSU priority with starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam int BE_W  = XLEN / 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} owner_t;

  owner_t            resp_owner;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;
  logic              if_gnt;
  logic              lsu_gnt;
  logic              sram_we;
  logic [BE_W-1:0]   sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [XLEN-1:0]   sram_wdata;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIM));

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign if_gnt  = rst_n & bus.if_req & (~bus.lsu_req | starved);
  assign lsu_gnt = rst_n & bus.lsu_req & ~if_gnt;

  always_comb begin
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (if_gnt) begin
      sram_be    = '1;
      sram_addr  = bus.if_addr & ~ADDR_W'(3);
      sram_wdata = bus.lsu_wdata;
    end else if (lsu_gnt) begin
      sram_we    = bus.lsu_we;
      sram_be    = bus.lsu_we ? bus.lsu_be : '1;
      sram_addr  = bus.lsu_addr & ~ADDR_W'(3);
      sram_wdata = bus.lsu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (if_gnt)
        resp_owner <= OWN_IF;
      else if (lsu_gnt && !bus.lsu_we)
        resp_owner <= OWN_LSU;
      else
        resp_owner <= OWN_NONE;

      if (if_gnt || !bus.if_req)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.if_gnt     = if_gnt;
  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.sram_cs    = if_gnt | lsu_gnt;
  assign bus.sram_we    = sram_we;
  assign bus.sram_be    = sram_be;
  assign bus.sram_addr  = sram_addr;
  assign bus.sram_wdata = sram_wdata;

  assign bus.if_rvalid  = (resp_owner == OWN_IF);
  assign bus.lsu_rvalid = (resp_owner == OWN_LSU);
  assign bus.if_rdata   = bus.if_rvalid  ? bus.sram_rdata : '0;
  assign bus.lsu_rdata  = bus.lsu_rvalid ? bus.sram_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with SRAM model
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .XLEN(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .XLEN(32), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] if_q [$];
  logic [31:0] lsu_q [$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt = 0;
  logic exp_if_rv = 1'b0;
  logic exp_lsu_rv = 1'b0;
  logic g_if = 1'b0;
  logic g_lsu = 1'b0;
  logic [7:0]  if_log = '0;
  logic [7:0]  lsu_log = '0;
  logic [31:0] last_lsu_rdata = '0;

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_be[b]) mem[bus.sram_addr[7:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr[7:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    logic e_if, e_lsu, e_cs;
    logic [31:0] e_addr;
    @(negedge clk);
    check("one_rvalid", bus.if_rvalid & bus.lsu_rvalid, 0);
    check("if_rvalid", bus.if_rvalid, exp_if_rv);
    check("lsu_rvalid", bus.lsu_rvalid, exp_lsu_rv);
    if (exp_if_rv) check("if_rdata", bus.if_rdata, if_q.pop_front());
    else           check("if_rdata_idle", bus.if_rdata, 0);
    if (exp_lsu_rv) check("lsu_rdata", bus.lsu_rdata, lsu_q.pop_front());
    else            check("lsu_rdata_idle", bus.lsu_rdata, 0);
    last_lsu_rdata = bus.lsu_rdata;

    e_if  = bus.if_req && (!bus.lsu_req || cnt == LIM);
    e_lsu = bus.lsu_req && !e_if;
    e_cs  = e_if || e_lsu;
    e_addr = e_if ? (bus.if_addr & ~32'd3) : (e_lsu ? (bus.lsu_addr & ~32'd3) : 32'd0);
    check("if_gnt", bus.if_gnt, e_if);
    check("lsu_gnt", bus.lsu_gnt, e_lsu);
    check("sram_cs", bus.sram_cs, e_cs);
    check("sram_we", bus.sram_we, e_lsu && bus.lsu_we);
    check("sram_be", bus.sram_be, (e_lsu && bus.lsu_we) ? bus.lsu_be : (e_cs ? 4'hF : 4'h0));
    check("sram_addr", bus.sram_addr, e_addr);
    check("sram_wdata", bus.sram_wdata, e_cs ? bus.lsu_wdata : 32'd0);
    if_log  = {if_log[6:0], bus.if_gnt};
    lsu_log = {lsu_log[6:0], bus.lsu_gnt};

    exp_if_rv  = e_if;
    exp_lsu_rv = e_lsu && !bus.lsu_we;
    if (e_if) if_q.push_back(ref_mem[bus.if_addr[7:2]]);
    if (e_lsu && !bus.lsu_we) lsu_q.push_back(ref_mem[bus.lsu_addr[7:2]]);
    if (e_lsu && bus.lsu_we)
      for (int b = 0; b < 4; b++)
        if (bus.lsu_be[b]) ref_mem[bus.lsu_addr[7:2]][8*b +: 8] = bus.lsu_wdata[8*b +: 8];
    if (e_if || !bus.if_req) cnt = 0;
    else if (cnt < LIM) cnt++;
    g_if  = e_if;
    g_lsu = e_lsu;
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic req, input logic [31:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic drive_lsu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.lsu_req   = req;
    bus.lsu_we    = we;
    bus.lsu_be    = be;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
  endtask

  task automatic idle(input int n);
    drive_if(1'b0, 32'd0);
    drive_lsu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_gnt"}, bus.if_gnt, 0);
    check({tag, "_lsu_gnt"}, bus.lsu_gnt, 0);
    check({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    check({tag, "_lsu_rvalid"}, bus.lsu_rvalid, 0);
    check({tag, "_if_rdata"}, bus.if_rdata, 0);
    check({tag, "_lsu_rdata"}, bus.lsu_rdata, 0);
    check({tag, "_sram_bus"}, {bus.sram_cs, bus.sram_we, bus.sram_be, bus.sram_addr, bus.sram_wdata}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    bus.sram_rdata = '0;

    drive_if(1'b1, 32'h10);
    drive_lsu(1'b1, 1'b1, 4'hF, 32'h30, 32'h1234_5678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    drive_lsu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    idle(1);

    drive_if(1'b1, 32'h0C);
    drive_lsu(1'b1, 1'b0, 4'h0, 32'h14, 32'd0);
    repeat (3) step();
    check("contention_lsu", lsu_log[2:0], 3'b111);
    check("contention_if", if_log[2:0], 3'b000);
    idle(2);

    drive_if(1'b1, 32'h1C);
    drive_lsu(1'b1, 1'b0, 4'h0, 32'h24, 32'd0);
    repeat (6) step();
    check("starve_if", if_log[5:0], 6'b000010);
    check("starve_lsu", lsu_log[5:0], 6'b111101);
    idle(2);

    drive_lsu(1'b1, 1'b1, 4'b0010, 32'h23, 32'h0000_AB00);
    step();
    drive_lsu(1'b1, 1'b0, 4'h0, 32'h20, 32'd0);
    step();
    idle(1);
    check("store_byte1", last_lsu_rdata[15:8], 8'hAB);

    drive_if(1'b1, 32'h0);
    step();
    drive_if(1'b0, 32'd0);
    drive_lsu(1'b1, 1'b0, 4'h0, 32'h4, 32'd0);
    step();
    drive_lsu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_if(1'b1, 32'h8);
    step();
    idle(1);
    check("b2b_if_pattern", if_log[3:0], 4'b1010);
    check("b2b_lsu_pattern", lsu_log[3:0], 4'b0100);

    drive_if(1'b1, 32'h1A);
    step();
    drive_if(1'b0, 32'd0);
    drive_lsu(1'b1, 1'b1, 4'hF, 32'h18, 32'hCAFE_F00D);
    step();
    drive_lsu(1'b1, 1'b0, 4'h0, 32'h19, 32'd0);
    step();
    idle(1);
    check("store_after_read", last_lsu_rdata, 32'hCAFE_F00D);

    g_if = 1'b0;
    g_lsu = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!bus.if_req || g_if)
        drive_if(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)));
      if (!bus.lsu_req || g_lsu)
        drive_lsu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'($urandom_range(0, 255)), $urandom());
      step();
    end
    idle(2);

    drive_if(1'b1, 32'h10);
    step();
    check("pre_reset_rvalid", bus.if_rvalid, 1);
    #2 rst_n = 1'b0;
    bus.lsu_req = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_if_rv = 1'b0;
    exp_lsu_rv = 1'b0;
    if_q.delete();
    lsu_q.delete();
    cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step();
    check("post_reset_if", if_log[4:0], 5'b00001);
    check("post_reset_lsu", lsu_log[4:0], 5'b11110);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
